// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, operand
// widths and FSM state values.
package md_pkg;

    localparam int MD_OP_W = 3;
    localparam int MD_DW   = 32;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the controller/GRF and the multiply/divide unit.
interface md_unit_if;

    logic                         start;
    logic [md_pkg::MD_OP_W-1:0]   md_op;
    logic [md_pkg::MD_DW-1:0]     src_a;
    logic [md_pkg::MD_DW-1:0]     src_b;
    logic                         busy;
    logic [md_pkg::MD_DW-1:0]     hi;
    logic [md_pkg::MD_DW-1:0]     lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi, lo
    );

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue, staged, and committed after a fixed latency.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      clr,
    md_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MD_DW-1:0]  stage_hi_q, stage_hi_d;
    logic [MD_DW-1:0]  stage_lo_q, stage_lo_d;
    logic              div0_q, div0_d;
    logic [MD_DW-1:0]  hi_q, hi_d;
    logic [MD_DW-1:0]  lo_q, lo_d;

    logic signed [MD_DW-1:0]   a_s, b_s, b_s_safe;
    logic signed [2*MD_DW-1:0] prod_s;
    logic        [2*MD_DW-1:0] prod_u;
    logic signed [MD_DW-1:0]   quot_s, rem_s;
    logic        [MD_DW-1:0]   b_u_safe, quot_u, rem_u;
    logic                      b_zero, div_ovf;

    // Divisor of 1 stands in for both zero and the INT_MIN/-1 overflow case:
    // the latter then yields exactly quotient=0x80000000, remainder=0.
    always_comb begin
        a_s      = $signed(bus.src_a);
        b_s      = $signed(bus.src_b);
        b_zero   = (bus.src_b == '0);
        div_ovf  = (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
        b_s_safe = (b_zero || div_ovf) ? 32'sd1 : b_s;
        b_u_safe = b_zero ? 32'd1 : bus.src_b;
        prod_s   = $signed({{MD_DW{bus.src_a[MD_DW-1]}}, bus.src_a})
                 * $signed({{MD_DW{bus.src_b[MD_DW-1]}}, bus.src_b});
        prod_u   = {{MD_DW{1'b0}}, bus.src_a} * {{MD_DW{1'b0}}, bus.src_b};
        quot_s   = a_s / b_s_safe;
        rem_s    = a_s % b_s_safe;
        quot_u   = bus.src_a / b_u_safe;
        rem_u    = bus.src_a % b_u_safe;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_hi_d = stage_hi_q;
        stage_lo_d = stage_lo_q;
        div0_d     = div0_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        MD_MULT: begin
                            {stage_hi_d, stage_lo_d} = prod_s;
                            div0_d  = 1'b0;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_BUSY;
                        end
                        MD_MULTU: begin
                            {stage_hi_d, stage_lo_d} = prod_u;
                            div0_d  = 1'b0;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_BUSY;
                        end
                        MD_DIV: begin
                            stage_hi_d = rem_s;
                            stage_lo_d = quot_s;
                            div0_d     = b_zero;
                            cnt_d      = DIV_LOAD;
                            state_d    = ST_BUSY;
                        end
                        MD_DIVU: begin
                            stage_hi_d = rem_u;
                            stage_lo_d = quot_u;
                            div0_d     = b_zero;
                            cnt_d      = DIV_LOAD;
                            state_d    = ST_BUSY;
                        end
                        MD_MTHI: hi_d = bus.src_a;
                        MD_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            default: begin
                // Further starts are ignored here; only the countdown matters.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!div0_q) begin
                        hi_d = stage_hi_q;
                        lo_d = stage_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Staged result is pure data; an aborted op simply never commits it.
    always_ff @(posedge clk) begin
        stage_hi_q <= stage_hi_d;
        stage_lo_q <= stage_lo_d;
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
